// File: rtl/sec_tick_monitor_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sec_tick_monitor_if : tick input and measurement/status bundle of the monitor
// Rev 1.0
// -----------------------------------------------------------------------------
interface sec_tick_monitor_if #(
  parameter int CNT_W = 28
);
  logic             i_tick;
  logic             o_rise;
  logic             o_meas_vld;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic             o_locked;
  logic             o_fault;
  logic [7:0]       o_err_cnt;
  logic [5:0]       o_sec_cnt;

  modport slave (
    input  i_tick,
    output o_rise, o_meas_vld, o_period, o_high,
    output o_locked, o_fault, o_err_cnt, o_sec_cnt
  );

  modport master (
    output i_tick,
    input  o_rise, o_meas_vld, o_period, o_high,
    input  o_locked, o_fault, o_err_cnt, o_sec_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sec_tick_monitor.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sec_tick_monitor : checks a ~1 Hz 50/50 tick (period, duty, timeout) and counts seconds
// Build option TICK_MON_DEGLITCH_EN adds a 4-cycle input stability filter. Rev 1.0
// -----------------------------------------------------------------------------
module sec_tick_monitor #(
  parameter int CLK_FREQ   = 96000000,
  parameter int TOL_CYCLES = CLK_FREQ / 1000,
  parameter int CNT_W      = 28
) (
  input wire                i_clk,
  input wire                i_rst,
  sec_tick_monitor_if.slave mon
);

  localparam logic [CNT_W-1:0]        c_sat    = CNT_W'(2 * CLK_FREQ);
  localparam logic [CNT_W-1:0]        c_one    = CNT_W'(1);
  localparam logic signed [CNT_W+1:0] c_freq_s = (CNT_W+2)'(CLK_FREQ);
  localparam logic signed [CNT_W+1:0] c_tol_s  = (CNT_W+2)'(TOL_CYCLES);
  localparam logic signed [CNT_W+1:0] c_tol2_s = (CNT_W+2)'(2 * TOL_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic lvl;
  logic rise_det;

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             rise_q;
  logic             meas_vld_q, meas_vld_d;
  logic             tmo_pend_q, tmo_pend_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [5:0]       sec_cnt_q, sec_cnt_d;

  logic timeout;
  logic meas_good;
  logic publish;
  logic err_inc;
  logic sec_inc;

  logic signed [CNT_W+1:0] per_s, hi2_s, per_dev, duty_dev, per_abs, duty_abs;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= mon.i_tick;
      s2_q <= s1_q;
      s3_q <= lvl;
    end
  end

`ifdef TICK_MON_DEGLITCH_EN
  // Level follows s2 only after four consecutive samples disagree with it.
  logic       filt_q, filt_d;
  logic [1:0] stab_q, stab_d;

  always_comb begin
    filt_d = filt_q;
    stab_d = 2'd0;
    if (s2_q != filt_q) begin
      if (stab_q == 2'd3) filt_d = s2_q;
      else                stab_d = stab_q + 2'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      filt_q <= 1'b0;
      stab_q <= 2'd0;
    end else begin
      filt_q <= filt_d;
      stab_q <= stab_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  assign rise_det = lvl & ~s3_q;

  // Measurement counters restart at 1 so the rise cycle itself is counted.
  always_comb begin
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    if (rise_det) begin
      per_cnt_d = c_one;
      hi_cnt_d  = c_one;
    end else begin
      if (per_cnt_q != c_sat)        per_cnt_d = per_cnt_q + c_one;
      if (lvl && (hi_cnt_q != c_sat)) hi_cnt_d  = hi_cnt_q + c_one;
    end
  end

  always_comb begin
    per_s    = $signed({2'b00, per_cnt_q});
    hi2_s    = $signed({1'b0, hi_cnt_q, 1'b0});
    per_dev  = per_s - c_freq_s;
    duty_dev = hi2_s - per_s;
    per_abs  = per_dev[CNT_W+1]  ? -per_dev  : per_dev;
    duty_abs = duty_dev[CNT_W+1] ? -duty_dev : duty_dev;
  end

  assign meas_good = (per_abs <= c_tol_s) && (duty_abs <= c_tol2_s);
  assign timeout   = ((state_q == ST_ARM) || (state_q == ST_LOCKED)) && (per_cnt_q == c_sat);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // After a timeout the next rise only re-arms: the period it closes is undefined.
  always_comb begin
    state_d    = state_q;
    tmo_pend_d = tmo_pend_q;
    publish    = 1'b0;
    err_inc    = 1'b0;
    sec_inc    = 1'b0;
    if (timeout) begin
      state_d    = ST_FAULT;
      tmo_pend_d = 1'b1;
      err_inc    = 1'b1;
    end else if (rise_det) begin
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        default: begin
          if (tmo_pend_q) begin
            state_d    = ST_ARM;
            tmo_pend_d = 1'b0;
          end else begin
            publish = 1'b1;
            if (meas_good) begin
              state_d = ST_LOCKED;
              sec_inc = 1'b1;
            end else begin
              state_d = ST_FAULT;
              err_inc = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    period_d   = period_q;
    high_d     = high_q;
    meas_vld_d = publish;
    if (publish) begin
      period_d = per_cnt_q;
      high_d   = hi_cnt_q;
    end
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    sec_cnt_d = sec_cnt_q;
    if (sec_inc) sec_cnt_d = (sec_cnt_q == 6'd59) ? 6'd0 : sec_cnt_q + 6'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      per_cnt_q  <= '0;
      hi_cnt_q   <= '0;
      period_q   <= '0;
      high_q     <= '0;
      rise_q     <= 1'b0;
      meas_vld_q <= 1'b0;
      tmo_pend_q <= 1'b0;
      err_cnt_q  <= 8'd0;
      sec_cnt_q  <= 6'd0;
    end else begin
      per_cnt_q  <= per_cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      rise_q     <= rise_det;
      meas_vld_q <= meas_vld_d;
      tmo_pend_q <= tmo_pend_d;
      err_cnt_q  <= err_cnt_d;
      sec_cnt_q  <= sec_cnt_d;
    end
  end

  assign mon.o_rise     = rise_q;
  assign mon.o_meas_vld = meas_vld_q;
  assign mon.o_period   = period_q;
  assign mon.o_high     = high_q;
  assign mon.o_locked   = (state_q == ST_LOCKED);
  assign mon.o_fault    = (state_q == ST_FAULT);
  assign mon.o_err_cnt  = err_cnt_q;
  assign mon.o_sec_cnt  = sec_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sec_tick_monitor.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sec_tick_monitor : table vectors, corner sequences and random ticks vs a period-level model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_sec_tick_monitor;

  localparam int FREQ  = 100;
  localparam int TOL   = 2;
  localparam int CNT_W = 10;
`ifdef TICK_MON_DEGLITCH_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int h; int l;
    int vld; int per; int hi; int lk; int flt; int err; int sec;
    int stall_err;
  } vec_t;

  typedef struct {
    int vld; int per; int hi; int lk; int flt; int err; int sec;
  } exp_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  exp_t exp_q[$];
  vec_t tbl[14];

  // model state (period-level view of the monitor)
  int m_st;  // 0 idle, 1 arm, 2 locked, 3 fault
  int m_tf;
  int m_per, m_hi, m_err, m_sec;

  sec_tick_monitor_if #(.CNT_W(CNT_W)) bus ();

  sec_tick_monitor #(
    .CLK_FREQ  (FREQ),
    .TOL_CYCLES(TOL),
    .CNT_W     (CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .mon  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // every rise seen on the DUT is matched against the next expected record
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_meas_vld) chk("vld_aligned_with_rise", int'(bus.o_rise), 1);
      if (bus.o_rise) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rise: got rise expected none at %0t", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("meas_vld", int'(bus.o_meas_vld), e.vld);
          chk("period",   int'(bus.o_period),   e.per);
          chk("high",     int'(bus.o_high),     e.hi);
          chk("locked",   int'(bus.o_locked),   e.lk);
          chk("fault",    int'(bus.o_fault),    e.flt);
          chk("err_cnt",  int'(bus.o_err_cnt),  e.err);
          chk("sec_cnt",  int'(bus.o_sec_cnt),  e.sec);
        end
      end
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic exp_t mk(input int vld, input int per, input int hi, input int lk,
                              input int flt, input int err, input int sec);
    exp_t e;
    e.vld = vld; e.per = per; e.hi = hi; e.lk = lk; e.flt = flt; e.err = err; e.sec = sec;
    return e;
  endfunction

  // Expected outputs at a rise that closes a previous high/low segment.
  function automatic exp_t model_rise(input int first, input int ph, input int pl);
    int p, h, vld;
    p   = ph + pl;
    vld = 0;
    if (first != 0) begin
      m_st = 1;
    end else if ((m_st == 1 || m_st == 2) && p >= 2 * FREQ) begin
      m_err = imin(m_err + 1, 255);
      m_st  = 3;
      m_tf  = 1;
      if (p > 2 * FREQ) begin
        m_st = 1;
        m_tf = 0;
      end
    end else if (m_st == 3 && m_tf != 0) begin
      m_st = 1;
      m_tf = 0;
    end else begin
      p     = imin(p, 2 * FREQ);
      h     = imin(ph, 2 * FREQ);
      m_per = p;
      m_hi  = h;
      vld   = 1;
      if (iabs(p - FREQ) <= TOL && iabs(2 * h - p) <= 2 * TOL) begin
        m_st  = 2;
        m_sec = (m_sec + 1) % 60;
      end else begin
        m_st  = 3;
        m_err = imin(m_err + 1, 255);
      end
    end
    return mk(vld, m_per, m_hi, int'(m_st == 2), int'(m_st == 3), m_err, m_sec);
  endfunction

  task automatic drive_seg(input int h, input int l, input int lat_chk, input int stall_err);
    bus.i_tick = 1'b1;
    if (lat_chk != 0) begin
      for (int i = 0; i <= LAT + 1; i++) begin
        @(negedge clk);
        chk("rise_latency", int'(bus.o_rise), int'(i == LAT));
      end
      repeat (h - LAT - 2) @(negedge clk);
    end else begin
      repeat (h) @(negedge clk);
    end
    bus.i_tick = 1'b0;
    if (stall_err >= 0) begin
      repeat (230 - h) @(negedge clk);
      chk("stall_fault", int'(bus.o_fault), 1);
      chk("stall_err_cnt", int'(bus.o_err_cnt), stall_err);
      repeat (l - 230 + h) @(negedge clk);
    end else begin
      repeat (l) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    chk("pending_rises_before_reset", exp_q.size(), 0);
    exp_q.delete();
    bus.i_tick = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_st = 0; m_tf = 0; m_per = 0; m_hi = 0; m_err = 0; m_sec = 0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    bus.i_tick = 1'b0;

    //          h    l  vld per  hi lk flt err sec stall
    tbl[0]  = '{50,  50, 0,   0,  0, 0, 0, 0, 0, -1};
    tbl[1]  = '{50,  50, 1, 100, 50, 1, 0, 0, 1, -1};
    tbl[2]  = '{50,  50, 1, 100, 50, 1, 0, 0, 2, -1};
    tbl[3]  = '{52,  51, 1, 100, 50, 1, 0, 0, 3, -1};
    tbl[4]  = '{50,  50, 1, 103, 52, 0, 1, 1, 3, -1};
    tbl[5]  = '{50,  50, 1, 100, 50, 1, 0, 1, 4, -1};
    tbl[6]  = '{60,  40, 1, 100, 50, 1, 0, 1, 5, -1};
    tbl[7]  = '{60,  40, 1, 100, 60, 0, 1, 2, 5, -1};
    tbl[8]  = '{50,  50, 1, 100, 60, 0, 1, 3, 5, -1};
    tbl[9]  = '{51,  50, 1, 100, 50, 1, 0, 3, 6, -1};
    tbl[10] = '{50, 250, 1, 101, 51, 1, 0, 3, 7,  4};
    tbl[11] = '{50,  50, 0, 101, 51, 0, 0, 4, 7, -1};
    tbl[12] = '{50,  50, 1, 100, 50, 1, 0, 4, 8, -1};
    tbl[13] = '{50,  50, 1, 100, 50, 1, 0, 4, 9, -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_locked", int'(bus.o_locked), 0);
    chk("idle_fault",  int'(bus.o_fault),  0);
    chk("idle_err",    int'(bus.o_err_cnt), 0);

    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(mk(tbl[i].vld, tbl[i].per, tbl[i].hi, tbl[i].lk,
                         tbl[i].flt, tbl[i].err, tbl[i].sec));
      drive_seg(tbl[i].h, tbl[i].l, int'(i == 0), tbl[i].stall_err);
    end

    // asynchronous reset between clock edges, tick toggling while held
    chk("pending_rises_before_async_reset", exp_q.size(), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_locked", int'(bus.o_locked),   0);
    chk("async_rst_sec",    int'(bus.o_sec_cnt),  0);
    chk("async_rst_err",    int'(bus.o_err_cnt),  0);
    chk("async_rst_period", int'(bus.o_period),   0);
    chk("async_rst_high",   int'(bus.o_high),     0);
    chk("async_rst_fault",  int'(bus.o_fault),    0);
    chk("async_rst_vld",    int'(bus.o_meas_vld), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.i_tick = ~bus.i_tick;
      chk("rst_hold_rise", int'(bus.o_rise), 0);
    end
    bus.i_tick = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_locked", int'(bus.o_locked), 0);

    // 60 locked rises wrap the seconds counter
    for (int n = 0; n <= 60; n++) begin
      if (n == 0) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      else        exp_q.push_back(mk(1, 100, 50, 1, 0, 0, n % 60));
      drive_seg(50, 50, 0, -1);
    end
    chk("sec_wrap", int'(bus.o_sec_cnt), 0);

    // 2-cycle glitch inside the low phase
    exp_q.push_back(mk(1, 100, 50, 1, 0, 0, 1));
    drive_seg(50, 20, 0, -1);
`ifdef TICK_MON_DEGLITCH_EN
    drive_seg(2, 28, 0, -1);
    exp_q.push_back(mk(1, 100, 50, 1, 0, 0, 2));
    drive_seg(50, 50, 0, -1);
    exp_q.push_back(mk(1, 100, 50, 1, 0, 0, 3));
    drive_seg(50, 50, 0, -1);
    chk("glitch_err_cnt", int'(bus.o_err_cnt), 0);
`else
    exp_q.push_back(mk(1, 70, 50, 0, 1, 1, 1));
    drive_seg(2, 28, 0, -1);
    exp_q.push_back(mk(1, 30, 2, 0, 1, 2, 1));
    drive_seg(50, 50, 0, -1);
    exp_q.push_back(mk(1, 100, 50, 1, 0, 2, 2));
    drive_seg(50, 50, 0, -1);
    chk("glitch_err_cnt", int'(bus.o_err_cnt), 2);
`endif

    // error counter saturation with a stream of bad periods
    do_reset();
    for (int n = 0; n <= 261; n++) begin
      if (n == 0) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      else        exp_q.push_back(mk(1, 40, 20, 0, 1, imin(n, 255), 0));
      drive_seg(20, 20, 0, -1);
    end
    chk("err_saturated", int'(bus.o_err_cnt), 255);

    // randomized segments against the model
    do_reset();
    begin
      int ph, pl, h, l, r;
      ph = 0;
      pl = 0;
      for (int i = 0; i < 200; i++) begin
        r = $urandom_range(0, 9);
        if (r <= 5) begin
          h = $urandom_range(47, 53);
          l = $urandom_range(46, 54);
        end else if (r <= 7) begin
          h = $urandom_range(5, 90);
          l = $urandom_range(5, 90);
        end else if (r == 8) begin
          h = 50;
          l = 250;
        end else begin
          h = $urandom_range(50, 60);
          l = 100 - h;
        end
        exp_q.push_back(model_rise(int'(i == 0), ph, pl));
        drive_seg(h, l, 0, -1);
        ph = h;
        pl = l;
      end
    end

    repeat (20) @(negedge clk);
    chk("pending_rises_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sec_tick_monitor.md
Name: sec_tick_monitor

Overview:
- Receive-side partner of the half-second square-wave tick generator. Takes a slow 50/50 tick, nominally 1 Hz, as input.
- Synchronises the tick and detects its edges.
- Measures period and high time in i_clk cycles and checks both against tolerance. Flags lock, fault and timeout.
- Keeps a 0..59 seconds count while locked. Sits between the tick source and display/timekeeping logic.

Parameters:
- CLK_FREQ, 96000000: i_clk frequency in Hz; the nominal tick period in cycles.
- TOL_CYCLES, CLK_FREQ/1000: allowed period deviation in cycles; the duty check uses 2*TOL_CYCLES.
- CNT_W, 28: width of the measurement counters. Must satisfy 2^CNT_W > 2*CLK_FREQ.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  asynchronous tick input, nominal 0.5 s high / 0.5 s low
- o_rise  out  1  one-cycle pulse per accepted rising edge
- o_meas_vld  out  1  one-cycle pulse when o_period/o_high are updated
- o_period  out  CNT_W  cycles between the last two accepted rises
- o_high  out  CNT_W  high cycles within that period
- o_locked  out  1  high while state==LOCKED
- o_fault  out  1  high while state==FAULT
- o_err_cnt  out  8  count of bad measurements plus timeouts; saturates at 255
- o_sec_cnt  out  6  seconds counter, 0..59

Behaviour:
- Reset: all flops are cleared immediately, including the synchroniser. Every output is 0 and state is IDLE. A reset mid-measurement discards the partial counts.
- Synchroniser: s1 <= i_tick, s2 <= s1, s3 <= s2.
  - rise_det = s2 & ~s3.
  - o_rise <= rise_det (registered).
  - If i_tick is first sampled high at edge k, o_rise is high for exactly one cycle after edge k+2.
- Counters:
  - per_cnt increments every cycle. On rise_det it loads 1.
  - hi_cnt increments when s2=1. On rise_det it loads 1.
  - Both saturate at 2*CLK_FREQ; they never wrap.
  - Ideal input with period P and high time H yields o_period=P and o_high=H.
- States: IDLE, ARM, LOCKED, FAULT.
  - IDLE: on rise_det go to ARM. No measurement is published.
  - ARM, LOCKED, FAULT, on rise_det:
    - o_period <= per_cnt; o_high <= hi_cnt; o_meas_vld pulses one cycle later, aligned with o_rise.
    - The measurement is good iff |per_cnt-CLK_FREQ| <= TOL_CYCLES and |2*hi_cnt-per_cnt| <= 2*TOL_CYCLES. Use signed arithmetic at width CNT_W+2.
    - Good: go to LOCKED. Bad: go to FAULT and increment o_err_cnt (saturating).
  - Timeout: per_cnt reaches 2*CLK_FREQ while in ARM or LOCKED.
    - Go to FAULT and increment o_err_cnt once; no further increments while saturated.
    - The next rise_det goes to ARM, not LOCKED, because that period is undefined; o_period/o_high are not updated on that rise.
  - Timeout takes priority over a simultaneous rise_det.
- o_sec_cnt:
  - Increments on a rise_det whose measurement is good, i.e. the transition into or staying in LOCKED. It does not count rises in other states.
  - Wraps 59 -> 0.
  - Holds its value in FAULT and ARM. Cleared only by reset.
- No debounce in the base build. Input pulses shorter than one i_clk cycle may be missed.

Optional Feature:
- Macro TICK_MON_DEGLITCH_EN.
- When defined: a 4-cycle stability filter sits between s2 and s3. The filtered level changes only after s2 has held the new value for 4 consecutive cycles.
  - o_rise latency becomes k+6.
  - Any pulse shorter than 4 cycles is ignored.
  - hi_cnt counts on the filtered level.
- When undefined: s2 feeds s3 directly, with the latency above.

Test Plan (sim with CLK_FREQ=100, TOL_CYCLES=2, CNT_W=10):
- Reset: i_rst=1 asserted asynchronously between clock edges -> all outputs 0 immediately, state IDLE; i_tick toggling during reset is ignored.
- Ideal tick, 50 high / 50 low:
  - First rise -> o_rise pulse at k+2; ARM; no o_meas_vld.
  - Second rise -> o_period=100, o_high=50, o_meas_vld=1, o_locked=1, o_sec_cnt=1.
  - After 60 locked rises -> o_sec_cnt wraps to 0.
- Period 103 (52/51) after lock -> |3|>2: FAULT, o_err_cnt=1, o_locked=0, o_sec_cnt holds. Next period of 100 (50/50) -> LOCKED, o_sec_cnt increments.
- Duty 60/40, period 100 -> |120-100|=20>4: FAULT, o_err_cnt increments each period.
- Stuck input: hold i_tick low after a rise -> at per_cnt=200 FAULT, o_err_cnt +1 exactly once. Next rise -> ARM with no update. Following ideal rise -> LOCKED.
- 2-cycle high glitch:
  - Without TICK_MON_DEGLITCH_EN -> o_rise pulses and a bad measurement is recorded.
  - With TICK_MON_DEGLITCH_EN -> no o_rise, counters unaffected.
